fdc_img_bridge: RTL and testbench
=================================

// Module: fdc_img_bridge
// PURPOSE
//  Sector server sitting directly downstream of the u765 FDC's SD-style block port.
//  Answers sd_rd/sd_wr sector requests for drives 0/1 from a byte-wide memory holding both disk images.
//  Streams 512 bytes into/out of the FDC sector buffer.
//  Replaces the host (MiST/MiSTer I/O) side when images live in SDRAM/BRAM.
// PARAMETERS
//  ADDR_W     24         memory byte-address width
//  IMG0_BASE  'h000000   byte base address of drive-0 image
//  IMG1_BASE  'h400000   byte base address of drive-1 image
// PORTS
//  clk_sys       in   1       system clock; all logic on rising edge
//  reset_n       in   1       async active-low reset
//  img_mounted   in   2       per-drive pulse; latches img_size (and img_wp) for that drive
//  img_wp        in   1       write-protect, latched with img_mounted
//  img_size      in   32      image size in bytes, latched with img_mounted
//  sd_lba        in   32      sector number from FDC; sampled when request accepted
//  sd_rd         in   2       per-drive read request (level, held until sd_ack seen)
//  sd_wr         in   2       per-drive write request (level)
//  sd_ack        out  1       transfer in progress
//  sd_buff_addr  out  9       byte index into FDC sector buffer
//  sd_buff_dout  out  8       read data to FDC buffer
//  sd_buff_din   in   8       write data from FDC buffer; valid 1 cycle after sd_buff_addr
//  sd_buff_wr    out  1       1-cycle strobe: write sd_buff_dout at sd_buff_addr
//  mem_addr      out  ADDR_W  memory byte address
//  mem_rd/mem_wr out  1       memory request, held until mem_ack
//  mem_dout      out  8       write data to memory
//  mem_din       in   8       read data, valid while mem_ack=1
//  mem_ack       in   1       1-cycle completion pulse
//  err           out  1       sticky: out-of-range or protected access; cleared at next accepted request
// BEHAVIOUR
//  Reset: all outputs 0, size/wp latches 0, FSM IDLE. Reset mid-transfer abandons it immediately.
//  IDLE: scan in the order rd[0], wr[0], rd[1], wr[1]; take the first set bit.
//   Latch drive, direction and sd_lba, plus a snapshot of that drive's size/wp.
//   Compute base + lba*512 (ADDR_W wrap).
//   range_ok = (lba*512 + 512) <= size, evaluated at 41 bits.
//  ACK: sd_ack=1, idx=0; sd_ack then stays high until DONE.
//  Read path RD_REQ -> RD_PUT, per byte:
//   RD_REQ holds mem_rd until mem_ack.
//   The cycle after mem_ack: sd_buff_wr=1, sd_buff_addr=idx, sd_buff_dout=mem_din (captured at ack).
//   Then idx++. Minimum 2 cycles/byte.
//   Out of range: no mem access; writes 0x00, sets err.
//  Write path WR_ADDR -> WR_REQ, per byte:
//   WR_ADDR drives sd_buff_addr=idx.
//   Next cycle captures sd_buff_din into mem_dout and raises mem_wr until mem_ack; then idx++.
//   Out of range: all 512 bytes are still walked, mem_wr is never raised, err is set.
//  After idx=511 completes -> DONE: sd_ack=0.
//   Stay in DONE until the served request bit is low, then IDLE (no double service).
//  img_mounted during a transfer updates the latches only; the active transfer keeps its snapshot.
//  Size 0 (no image) => every access is out of range.
//  Simultaneous img_mounted on both bits latches both drives from the same img_size/img_wp.
// CONFIGURATION
//  FDC_BRIDGE_WP_EN defined: write with latched wp=1 is treated as out of range.
//   Full 512-byte walk, no mem_wr, err set.
//  Undefined: img_wp is ignored; writes always reach memory when in range.
// STRUCTURE
//  Package fdc_bridge_pkg: state_t enum (IDLE, ACK, RD_REQ, RD_PUT, WR_ADDR, WR_REQ, DONE).
//   Constant SECTOR_BYTES=512; function sector_addr(base, lba).
//  Single module, no sub-modules; per-drive size/wp latches as 2-entry arrays.
// TESTING
//  1. Mount d0 size 'h2000; sd_rd=01, lba=3; memory returns addr[7:0].
//     -> 512 sd_buff_wr, byte k = 'h(600+k)[7:0]; mem_addr 'h600..'h7FF; err=0.
//  2. Mount d1 size 'h1000; sd_wr=10, lba=1; FDC buffer holds ~k.
//     -> mem writes at 'h400200..'h4003FF, data ~k; sd_ack falls after byte 511.
//  3. d0 size 'h400, rd lba=2 -> 512 zeros written to buffer, no mem_rd, err=1.
//  4. sd_rd=11 and sd_wr=01 together -> order rd0, wr0, rd1.
//     Each served once; the bit held high in DONE causes no re-service.
//  5. reset_n low at byte 100 of a read -> sd_ack/mem_rd/sd_buff_wr low at once.
//     Next request restarts at idx 0.
//  6. FDC_BRIDGE_WP_EN, d0 mounted wp=1, sd_wr=01 -> no mem_wr, err=1.
//     Macro undefined -> 512 mem_wr.

Source files
------------

// File: rtl/fdc_bridge_pkg.sv
// Shared types and helpers for the FDC image bridge.
// States, sector size and the sector-to-byte-address mapping.
package fdc_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RD_REQ,
        RD_PUT,
        WR_ADDR,
        WR_REQ,
        DONE
    } state_t;

    localparam int SECTOR_BYTES = 512;

    // Wide result; the caller truncates to its memory address width.
    function automatic logic [40:0] sector_addr(input logic [40:0] base, input logic [31:0] lba);
        return base + {lba, 9'd0};
    endfunction

endpackage

// File: rtl/fdc_img_bridge.sv
// Sector server for the u765 FDC SD-style block port, backed by a byte-wide image memory.
// Define FDC_BRIDGE_WP_EN to make writes to a write-protected drive behave as out of range.
module fdc_img_bridge
    import fdc_bridge_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] IMG0_BASE = 'h000000,
    parameter logic [ADDR_W-1:0] IMG1_BASE = 'h400000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [1:0]        img_mounted,
    input  logic              img_wp,
    input  logic [31:0]       img_size,
    input  logic [31:0]       sd_lba,
    input  logic [1:0]        sd_rd,
    input  logic [1:0]        sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_buff_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_ack,
    output logic              err
);

    state_t            state, state_nx;
    logic [31:0]       size_lat [0:1];
    logic              wp_lat   [0:1];
    logic              cur_drive;
    logic              cur_wr;
    logic              cur_bad;
    logic [8:0]        idx;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              wr_cap;
    logic              err_q;

    logic              req_hit;
    logic              req_drive;
    logic              req_wr;
    logic              req_bad;
    logic              range_ok;
    logic [40:0]       end_off;
    logic [40:0]       req_base;
    logic [40:0]       req_addr_wide;
    logic              served_bit;
    logic              last_byte;

    // Fixed priority: rd0, wr0, rd1, wr1.
    always_comb begin
        req_hit   = 1'b1;
        req_drive = 1'b0;
        req_wr    = 1'b0;
        if (sd_rd[0]) begin
            req_drive = 1'b0;
        end else if (sd_wr[0]) begin
            req_wr = 1'b1;
        end else if (sd_rd[1]) begin
            req_drive = 1'b1;
        end else if (sd_wr[1]) begin
            req_drive = 1'b1;
            req_wr    = 1'b1;
        end else begin
            req_hit = 1'b0;
        end
    end

    assign end_off       = {sd_lba, 9'd0} + 41'(SECTOR_BYTES);
    assign range_ok      = end_off <= {9'd0, size_lat[req_drive]};
    assign req_base      = req_drive ? 41'(IMG1_BASE) : 41'(IMG0_BASE);
    assign req_addr_wide = sector_addr(req_base, sd_lba);

`ifdef FDC_BRIDGE_WP_EN
    assign req_bad = !range_ok || (req_wr && wp_lat[req_drive]);
`else
    assign req_bad = !range_ok;
    logic unused_wp;
    assign unused_wp = wp_lat[0] ^ wp_lat[1];
`endif

    assign served_bit = cur_wr ? sd_wr[cur_drive] : sd_rd[cur_drive];
    assign last_byte  = idx == 9'(SECTOR_BYTES - 1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        sd_ack     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        case (state)
            IDLE: begin
                if (req_hit) state_nx = ACK;
            end
            ACK: begin
                sd_ack   = 1'b1;
                state_nx = cur_wr ? WR_ADDR : RD_REQ;
            end
            RD_REQ: begin
                sd_ack = 1'b1;
                mem_rd = !cur_bad;
                if (cur_bad || mem_ack) state_nx = RD_PUT;
            end
            RD_PUT: begin
                sd_ack     = 1'b1;
                sd_buff_wr = 1'b1;
                state_nx   = last_byte ? DONE : RD_REQ;
            end
            WR_ADDR: begin
                sd_ack   = 1'b1;
                state_nx = WR_REQ;
            end
            WR_REQ: begin
                sd_ack = 1'b1;
                mem_wr = !cur_bad;
                if (cur_bad || mem_ack) state_nx = last_byte ? DONE : WR_ADDR;
            end
            DONE: begin
                // Wait for the FDC to drop the request so it is not served twice.
                if (!served_bit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                size_lat[i] <= '0;
                wp_lat[i]   <= 1'b0;
            end
            cur_drive <= 1'b0;
            cur_wr    <= 1'b0;
            cur_bad   <= 1'b0;
            idx       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_cap    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (img_mounted[i]) begin
                    size_lat[i] <= img_size;
                    wp_lat[i]   <= img_wp;
                end
            end
            case (state)
                IDLE: begin
                    if (req_hit) begin
                        cur_drive <= req_drive;
                        cur_wr    <= req_wr;
                        cur_bad   <= req_bad;
                        err_q     <= req_bad;
                        addr_q    <= req_addr_wide[ADDR_W-1:0];
                        idx       <= '0;
                    end
                end
                ACK: idx <= '0;
                RD_REQ: begin
                    if (cur_bad)      data_q <= 8'h00;
                    else if (mem_ack) data_q <= mem_din;
                end
                RD_PUT: begin
                    idx    <= idx + 9'd1;
                    addr_q <= addr_q + 1'b1;
                end
                WR_ADDR: wr_cap <= 1'b1;
                WR_REQ: begin
                    // Buffer data arrives one cycle after the address; hold it for slow acks.
                    wr_cap <= 1'b0;
                    if (wr_cap) data_q <= sd_buff_din;
                    if (cur_bad || mem_ack) begin
                        idx    <= idx + 9'd1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sd_buff_addr = idx;
    assign sd_buff_dout = data_q;
    assign mem_addr     = addr_q;
    assign mem_dout     = wr_cap ? sd_buff_din : data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fdc_img_bridge.sv
// Randomised bench for fdc_img_bridge: memory and FDC buffer models plus a sector-level reference.
// Honours FDC_BRIDGE_WP_EN in the same way as the design.
module tb_fdc_img_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [1:0]  img_mounted;
    logic        img_wp;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic        err;

    fdc_img_bridge dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .img_mounted(img_mounted), .img_wp(img_wp), .img_size(img_size),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [7:0]  mem_store [int];
    logic [7:0]  fdc_buf [512];
    logic [7:0]  cap_buf [512];
    logic [31:0] m_size [2];
    bit          m_wp [2];
    bit          exp_wr, exp_bad;
    int          exp_addr;
    int          rd_seen, wr_done;
    int          last_rd_addr;
    int          wait_cnt;
    bit          ack_was_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] mem_val(input int a);
        if (mem_store.exists(a)) return mem_store[a];
        return a[7:0];
    endfunction

    // FDC sector buffer: synchronous read, data one cycle after the address.
    initial begin
        int a;
        sd_buff_din = 8'h00;
        forever begin
            @(negedge clk_sys);
            a = int'(sd_buff_addr);
            @(posedge clk_sys);
            #1;
            sd_buff_din = fdc_buf[a];
        end
    end

    // Image memory: random 0-1 cycle latency, one-cycle ack pulse.
    initial begin
        mem_ack = 1'b0; mem_din = 8'h00; wait_cnt = 0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (!reset_n) begin
                mem_ack = 1'b0; wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                if (ack_was_wr) wr_done++;
            end else if (mem_rd || mem_wr) begin
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    mem_ack    = 1'b1;
                    ack_was_wr = mem_wr;
                    if (mem_rd) mem_din = mem_val(int'(mem_addr));
                    else        mem_store[int'(mem_addr)] = mem_dout;
                    wait_cnt = $urandom_range(0, 1);
                end
            end
        end
    end

    // Per-cycle comparison of the FDC-side and memory-side traffic against the sector model.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset_n) begin
                if (sd_buff_wr) begin
                    check("buf_wr_on_write", exp_wr, 0);
                    check("buf_addr", sd_buff_addr, rd_seen);
                    check("buf_data", sd_buff_dout,
                          exp_bad ? 8'h00 : mem_val((exp_addr + rd_seen) & 'hFFFFFF));
                    cap_buf[sd_buff_addr] = sd_buff_dout;
                    rd_seen++;
                end
                if (mem_rd) begin
                    check("mem_rd_allowed", exp_wr | exp_bad, 0);
                    check("mem_rd_addr", mem_addr, (exp_addr + rd_seen) & 'hFFFFFF);
                    last_rd_addr = int'(mem_addr);
                end
                if (mem_wr) begin
                    check("mem_wr_allowed", !exp_wr | exp_bad, 0);
                    check("mem_wr_addr", mem_addr, (exp_addr + wr_done) & 'hFFFFFF);
                    check("mem_wr_data", mem_dout, fdc_buf[wr_done & 511]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic mount(input logic [1:0] mask, input logic [31:0] size, input bit wp);
        img_mounted = mask; img_size = size; img_wp = wp;
        step();
        img_mounted = 2'b00;
        for (int i = 0; i < 2; i++) if (mask[i]) begin m_size[i] = size; m_wp[i] = wp; end
    endtask

    task automatic set_expect(input int d, input bit w, input int lba);
        longint end_off;
        end_off = (longint'(lba) + 1) * 512;
        exp_wr   = w;
        exp_addr = ((d == 1 ? 'h400000 : 0) + lba * 512) & 'hFFFFFF;
        exp_bad  = end_off > longint'(m_size[d]);
`ifdef FDC_BRIDGE_WP_EN
        if (w && m_wp[d]) exp_bad = 1'b1;
`endif
        rd_seen = 0;
        wr_done = 0;
    endtask

    task automatic wait_ack_rise();
        int t = 0;
        while (!sd_ack && t < 20) begin step(); t++; end
        check("ack_rise", sd_ack, 1);
    endtask

    // Serves every set request bit in priority order, checking each whole sector transfer.
    task automatic serve(input logic [1:0] rd, input logic [1:0] wr, input int lba0, input bit mid_mount);
        logic [1:0] prd, pwr;
        int lba, d, t, mm;
        bit w;
        prd = rd; pwr = wr; lba = lba0;
        sd_lba = lba; sd_rd = prd; sd_wr = pwr;
        while (prd != 2'b00 || pwr != 2'b00) begin
            if      (prd[0]) begin d = 0; w = 0; end
            else if (pwr[0]) begin d = 0; w = 1; end
            else if (prd[1]) begin d = 1; w = 0; end
            else             begin d = 1; w = 1; end
            set_expect(d, w, lba);
            wait_ack_rise();
            t = 0; mm = 0;
            while (sd_ack && t < 4000) begin
                step(); t++;
                if (mid_mount && mm == 0 && rd_seen >= 50) begin
                    img_mounted = (d == 1) ? 2'b10 : 2'b01; img_size = 0; img_wp = 1'b0; mm = 1;
                end else if (mm == 1) begin
                    img_mounted = 2'b00; m_size[d] = 0; m_wp[d] = 1'b0; mm = 2;
                end
            end
            check("ack_fall", sd_ack, 0);
            if (w) check("wr_bytes", wr_done, exp_bad ? 0 : 512);
            else   check("rd_bytes", rd_seen, 512);
            check("err", err, exp_bad);
            repeat ($urandom_range(1, 3)) begin step(); check("no_reservice", sd_ack, 0); end
            if (w) pwr[d] = 1'b0; else prd[d] = 1'b0;
            lba++;
            sd_lba = lba; sd_rd = prd; sd_wr = pwr;
        end
        repeat (3) begin step(); check("idle_after", sd_ack, 0); end
    endtask

    initial begin
        reset_n = 1'b0; img_mounted = 2'b00; img_wp = 1'b0; img_size = 0;
        sd_lba = 0; sd_rd = 2'b00; sd_wr = 2'b00;
        exp_wr = 0; exp_bad = 0; exp_addr = 0; rd_seen = 0; wr_done = 0; last_rd_addr = 0;
        m_size[0] = 0; m_size[1] = 0; m_wp[0] = 0; m_wp[1] = 0;
        for (int k = 0; k < 512; k++) begin fdc_buf[k] = 8'h00; cap_buf[k] = 8'h00; end
        repeat (3) step();
        check("rst_sd_ack", sd_ack, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_buff_wr", sd_buff_wr, 0);
        check("rst_buff_addr", sd_buff_addr, 0);
        check("rst_buff_dout", sd_buff_dout, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        step();

        $display("[TB] read drive 0 lba 3");
        mount(2'b01, 32'h2000, 1'b0);
        serve(2'b01, 2'b00, 3, 0);
        check("t1_byte0", cap_buf[0], 8'h00);
        check("t1_byte22", cap_buf[9'h22], 8'h22);
        check("t1_byte511", cap_buf[511], 8'hFF);
        check("t1_last_addr", last_rd_addr, 'h7FF);

        $display("[TB] write drive 1 lba 1");
        for (int k = 0; k < 512; k++) fdc_buf[k] = 8'(~k);
        mount(2'b10, 32'h1000, 1'b0);
        serve(2'b00, 2'b10, 1, 0);
        check("t2_first", mem_val('h400200), 8'hFF);
        check("t2_second", mem_val('h400201), 8'hFE);
        check("t2_last", mem_val('h4003FF), 8'h00);

        $display("[TB] range boundary on drive 0");
        mount(2'b01, 32'h400, 1'b0);
        serve(2'b01, 2'b00, 2, 0);
        check("t3_zero", cap_buf[5], 8'h00);
        check("t3_err", err, 1);
        serve(2'b01, 2'b00, 1, 0);
        check("t3_ok_err", err, 0);

        $display("[TB] priority rd0 wr0 rd1");
        mount(2'b11, 32'h800, 1'b0);
        for (int k = 0; k < 512; k++) fdc_buf[k] = 8'(k * 3 + 1);
        serve(2'b11, 2'b01, 1, 0);
        serve(2'b01, 2'b00, 4, 0);

        $display("[TB] reset mid-read");
        mount(2'b01, 32'h2000, 1'b0);
        sd_lba = 5; sd_rd = 2'b01;
        set_expect(0, 0, 5);
        wait_ack_rise();
        begin
            int t = 0;
            while (rd_seen < 100 && t < 2000) begin step(); t++; end
            check("t5_reached_100", rd_seen >= 100, 1);
        end
        reset_n = 1'b0;
        #1;
        check("t5_ack", sd_ack, 0);
        check("t5_mem_rd", mem_rd, 0);
        check("t5_buff_wr", sd_buff_wr, 0);
        check("t5_buff_addr", sd_buff_addr, 0);
        sd_rd = 2'b00;
        m_size[0] = 0; m_size[1] = 0; m_wp[0] = 0; m_wp[1] = 0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        mount(2'b01, 32'h2000, 1'b0);
        serve(2'b01, 2'b00, 7, 0);

        $display("[TB] mount during transfer");
        mount(2'b10, 32'h1000, 1'b0);
        serve(2'b10, 2'b00, 2, 1);
        serve(2'b10, 2'b00, 2, 0);

        $display("[TB] write-protected drive 0");
        for (int k = 0; k < 512; k++) fdc_buf[k] = 8'($urandom);
        mount(2'b01, 32'h2000, 1'b1);
        serve(2'b00, 2'b01, 0, 0);

        $display("[TB] random traffic");
        for (int r = 0; r < 6; r++) begin
            logic [1:0] rm, wm;
            logic [31:0] sz;
            for (int k = 0; k < 512; k++) fdc_buf[k] = 8'($urandom);
            case ($urandom_range(0, 4))
                0: sz = 0;
                1: sz = 32'h400;
                2: sz = 32'h1000;
                3: sz = 32'h2000;
                default: sz = 32'($urandom_range(1, 16)) * 512;
            endcase
            mount(2'($urandom_range(1, 3)), sz, 1'($urandom));
            rm = 2'($urandom); wm = 2'($urandom);
            if (rm == 2'b00 && wm == 2'b00) rm = 2'b01;
            serve(rm, wm, $urandom_range(0, 15), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
